// File: rtl/if_pipe_pkg.sv
// Shared instruction-fetch pipeline constants: default widths and the NOP encoding
// used by the fetch buffer and the decode stage.
package if_pipe_pkg;

  localparam int unsigned IF_DATA_W = 10;
  localparam int unsigned IF_ADDR_W = 10;

  localparam logic [IF_DATA_W-1:0] IF_NOP_INSTR = '0;

  localparam int unsigned IF_STALL_W = 16;

endpackage

// File: rtl/if_buf_ptr.sv
// Wrapping FIFO pointer for the fetch buffer; wraps naturally since DEPTH is a power of two.
module if_buf_ptr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(negedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/if_stage_buf.sv
// Fetch-to-decode buffer: DEPTH-entry {instr, pc} FIFO, flushable on redirect, NOP when empty.
// Optional stall counter port enabled by defining IF_BUF_STALL_CNT_EN.
module if_stage_buf
  import if_pipe_pkg::*;
#(
  parameter int unsigned           DATA_W    = IF_DATA_W,
  parameter int unsigned           ADDR_W    = IF_ADDR_W,
  parameter int unsigned           DEPTH     = 2,
  parameter logic [DATA_W-1:0]     NOP_INSTR = DATA_W'(IF_NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
`ifdef IF_BUF_STALL_CNT_EN
  output logic [IF_STALL_W-1:0]      stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              not_empty;
  logic              not_full;
  logic              push;
  logic              pop;

  assign not_empty = (count != '0);
  assign not_full  = (count != CNT_W'(DEPTH));

  // Handshake decode from registered occupancy; flush suppresses both sides.
  assign in_ready  = ~reset & not_full;
  assign out_valid = not_empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = not_empty & out_ready & ~flush;

  assign out_instr = not_empty ? mem_instr[rd_ptr] : NOP_INSTR;
  assign out_pc    = not_empty ? mem_pc[rd_ptr]    : '0;

  if_buf_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  if_buf_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is intentionally not reset; occupancy alone decides what is visible.
  always_ff @(negedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(negedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

`ifdef IF_BUF_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid head; survives flush.
  always_ff @(negedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (not_empty && !out_ready && (stall_cnt != {IF_STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + IF_STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_buf.sv
// Directed bench for if_stage_buf: DEPTH=2 and DEPTH=4 instances, falling-edge design.
module tb_if_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [9:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc;
  logic [1:0] a_count;

  logic       b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [9:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
  logic [2:0] b_count;

`ifdef IF_BUF_STALL_CNT_EN
  logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_stage_buf #(.DATA_W(10), .ADDR_W(10), .DEPTH(2), .NOP_INSTR(10'h000)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
`ifdef IF_BUF_STALL_CNT_EN
    .stall_cnt(a_stall_cnt),
`endif
    .count(a_count)
  );

  if_stage_buf #(.DATA_W(10), .ADDR_W(10), .DEPTH(4), .NOP_INSTR(10'h000)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
`ifdef IF_BUF_STALL_CNT_EN
    .stall_cnt(b_stall_cnt),
`endif
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [9:0] instr, input logic [9:0] pc);
    a_in_valid = 1'b1;
    a_in_instr = instr;
    a_in_pc    = pc;
    tick();
    a_in_valid = 1'b0;
  endtask

  logic [9:0] stream_tbl [4];
  int  m, pushed, popped;
  bit  rdy, mpush, mpop;

  initial begin
    stream_tbl[0] = 10'h00F;
    stream_tbl[1] = 10'h007;
    stream_tbl[2] = 10'h003;
    stream_tbl[3] = 10'h001;

    // Reset with a word offered; it must not be captured.
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_instr = 10'h3FF; a_in_pc = 10'h000; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_instr = 10'h000; b_in_pc = 10'h000; b_flush = 1'b0; b_out_ready = 1'b0;
    #1;
    chk("rst_in_ready_during", 32'(a_in_ready), 32'd0);
    tick();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_instr", 32'(a_out_instr), 32'h000);
    chk("rst_out_pc",    32'(a_out_pc),    32'h000);
    chk("rst_count",     32'(a_count),     32'd0);
    chk("rst_in_ready_held", 32'(a_in_ready), 32'd0);
    chk("rst_b_count",   32'(b_count),     32'd0);
    reset = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("rst_in_ready_after", 32'(a_in_ready), 32'd1);
    tick();
    chk("rst_no_capture", 32'(a_out_valid), 32'd0);

    // Streaming with decode always ready: one-edge latency, occupancy stays at 1.
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1;
      a_in_instr = stream_tbl[k];
      a_in_pc    = 10'(k);
      tick();
      chk($sformatf("stream_valid_%0d", k), 32'(a_out_valid), 32'd1);
      chk($sformatf("stream_instr_%0d", k), 32'(a_out_instr), 32'(stream_tbl[k]));
      chk($sformatf("stream_pc_%0d", k),    32'(a_out_pc),    32'(k));
      chk($sformatf("stream_count_%0d", k), 32'(a_count),     32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_drain_count", 32'(a_count), 32'd0);
    chk("stream_drain_nop",   32'(a_out_instr), 32'h000);

    // Back-pressure: fill, reject a third word, then drain in order.
    a_out_ready = 1'b0;
    push_a(10'h00F, 10'd0);
    chk("bp_count1", 32'(a_count), 32'd1);
    push_a(10'h007, 10'd1);
    chk("bp_count2",    32'(a_count),    32'd2);
    chk("bp_in_ready",  32'(a_in_ready), 32'd0);
    push_a(10'h003, 10'd2);
    chk("bp_full_count", 32'(a_count),     32'd2);
    chk("bp_full_head",  32'(a_out_instr), 32'h00F);
    chk("bp_full_pc",    32'(a_out_pc),    32'd0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_second_instr", 32'(a_out_instr), 32'h007);
    chk("bp_second_pc",    32'(a_out_pc),    32'd1);
    chk("bp_second_count", 32'(a_count),     32'd1);
    tick();
    chk("bp_empty_valid", 32'(a_out_valid), 32'd0);
    chk("bp_empty_count", 32'(a_count),     32'd0);

    // Flush at full with a word offered: everything dropped.
    a_out_ready = 1'b0;
    push_a(10'h00F, 10'd0);
    push_a(10'h007, 10'd1);
    chk("fl_pre_count", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 10'h005; a_in_pc = 10'd2;
    tick();
    chk("fl_count",    32'(a_count),     32'd0);
    chk("fl_valid",    32'(a_out_valid), 32'd0);
    chk("fl_nop",      32'(a_out_instr), 32'h000);
    chk("fl_pc",       32'(a_out_pc),    32'h000);
    chk("fl_in_ready", 32'(a_in_ready),  32'd1);
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    chk("fl_dropped", 32'(a_out_valid), 32'd0);

    // Flush beats a push that would otherwise land in a non-full buffer.
    push_a(10'h00F, 10'd0);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 10'h005; a_in_pc = 10'd3;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl2_count", 32'(a_count), 32'd0);
    push_a(10'h003, 10'd5);
    chk("fl2_refetch_instr", 32'(a_out_instr), 32'h003);
    chk("fl2_refetch_pc",    32'(a_out_pc),    32'd5);
    chk("fl2_refetch_count", 32'(a_count),     32'd1);
    a_out_ready = 1'b1;
    tick();
    chk("fl2_drain", 32'(a_count), 32'd0);

    // DEPTH=4 wrap-around: continuous offers, out_ready toggling, count-only model.
    m = 0; pushed = 0; popped = 0; rdy = 1'b0;
    for (int c = 0; c < 60 && popped < 10; c++) begin
      b_in_valid  = (pushed < 10);
      b_in_instr  = 10'(256 + pushed);
      b_in_pc     = 10'(pushed * 4);
      b_out_ready = rdy;
      #1;
      chk($sformatf("wrap_count_c%0d", c),    32'(b_count),    32'(m));
      chk($sformatf("wrap_in_ready_c%0d", c), 32'(b_in_ready), 32'(m != 4));
      chk($sformatf("wrap_valid_c%0d", c),    32'(b_out_valid), 32'(m != 0));
      mpush = b_in_valid && (m != 4);
      mpop  = (m != 0) && rdy;
      if (mpop) begin
        chk($sformatf("wrap_instr_%0d", popped), 32'(b_out_instr), 32'(10'(256 + popped)));
        chk($sformatf("wrap_pc_%0d", popped),    32'(b_out_pc),    32'(10'(popped * 4)));
        popped++;
      end
      if (mpush) pushed++;
      m = m + int'(mpush) - int'(mpop);
      tick();
      rdy = ~rdy;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    chk("wrap_all_popped", 32'(popped), 32'd10);
    chk("wrap_final_count", 32'(b_count), 32'd0);
    chk("wrap_final_valid", 32'(b_out_valid), 32'd0);

`ifdef IF_BUF_STALL_CNT_EN
    // Stall counter: five held cycles, survives flush, cleared by reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stall_reset0", 32'(a_stall_cnt), 32'd0);
    a_out_ready = 1'b0;
    push_a(10'h00F, 10'd0);
    chk("stall_after_push", 32'(a_stall_cnt), 32'd0);
    for (int s = 0; s < 5; s++) tick();
    chk("stall_five", 32'(a_stall_cnt), 32'd5);
    a_flush = 1'b1; a_out_ready = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("stall_flush_kept", 32'(a_stall_cnt), 32'd5);
    chk("stall_flush_count", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;
    tick();
    chk("stall_idle_kept", 32'(a_stall_cnt), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stall_reset_clear", 32'(a_stall_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
